// File: rtl/csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// csa_pipe_adder
//   Two-stage pipelined carry-select adder.
//   Stage 1 computes, for each BLK-bit segment, the sum and carry-out under
//   both carry-in hypotheses (0 and 1) and registers them.
//   Stage 2 ripples the real carry through one select mux per segment and
//   registers the final sum, carry-out and signed-overflow flag.
//   Valid/ready handshakes on both sides; one result per cycle when the
//   consumer keeps out_ready high.
//
// Ports
//   clk        rising-edge clock
//   rst        asynchronous active-high reset
//   in_valid   operand transfer request
//   in_ready   block can take operands this cycle (combinational)
//   a, b       WIDTH-bit operands
//   c_in       carry into bit 0
//   out_valid  s/c_out/ovf hold a valid result
//   out_ready  consumer takes the result this cycle
//   s          (a + b + c_in) mod 2^WIDTH
//   c_out      carry out of bit WIDTH-1
//   ovf        two's-complement overflow (carry into MSB xor c_out)
// ---------------------------------------------------------------------------
module csa_pipe_adder #(
  parameter int WIDTH = 32,
  parameter int BLK   = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             c_out,
  output logic             ovf
);

  localparam int NSEG = WIDTH / BLK;

  // Handshake / stall control
  logic r_v1;
  logic r_v2;
  logic w_adv1;
  logic w_adv2;
  logic w_in_fire;

  assign w_adv2    = !r_v2 || out_ready;
  assign w_adv1    = r_v1 && w_adv2;
  assign in_ready  = !r_v1 || w_adv2;
  assign w_in_fire = in_valid && in_ready;

  // Stage-1 candidate generation (combinational, from the raw operands)
  logic [BLK-1:0] w_sum0 [NSEG];
  logic [BLK-1:0] w_sum1 [NSEG];
  logic [NSEG-1:0] w_cout0;
  logic [NSEG-1:0] w_cout1;
  logic            w_p_msb;
  logic            w_msbc0;
  logic            w_msbc1;

  generate
    for (genvar gi = 0; gi < NSEG; gi++) begin : g_seg
      logic [BLK-1:0] w_a_seg;
      logic [BLK-1:0] w_b_seg;
      assign w_a_seg = a[gi*BLK +: BLK];
      assign w_b_seg = b[gi*BLK +: BLK];
      assign {w_cout0[gi], w_sum0[gi]} = {1'b0, w_a_seg} + {1'b0, w_b_seg};
      assign {w_cout1[gi], w_sum1[gi]} = {1'b0, w_a_seg} + {1'b0, w_b_seg}
                                         + {{BLK{1'b0}}, 1'b1};
    end
  endgenerate

  // The carry into the MSB falls out of the top segment's sum bit:
  // sum[msb] = p[msb] ^ carry_in[msb], so carry_in[msb] = sum[msb] ^ p[msb].
  assign w_p_msb = a[WIDTH-1] ^ b[WIDTH-1];
  assign w_msbc0 = w_sum0[NSEG-1][BLK-1] ^ w_p_msb;
  assign w_msbc1 = w_sum1[NSEG-1][BLK-1] ^ w_p_msb;

  // Stage-1 registers
  logic [BLK-1:0]  r_sum0 [NSEG];
  logic [BLK-1:0]  r_sum1 [NSEG];
  logic [NSEG-1:0] r_cout0;
  logic [NSEG-1:0] r_cout1;
  logic            r_msbc0;
  logic            r_msbc1;
  logic            r_cin;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_cout0 <= '0;
      r_cout1 <= '0;
      r_msbc0 <= 1'b0;
      r_msbc1 <= 1'b0;
      r_cin   <= 1'b0;
      for (int k = 0; k < NSEG; k++) begin
        r_sum0[k] <= '0;
        r_sum1[k] <= '0;
      end
    end else begin
      if (w_in_fire) begin
        r_v1    <= 1'b1;
        r_cout0 <= w_cout0;
        r_cout1 <= w_cout1;
        r_msbc0 <= w_msbc0;
        r_msbc1 <= w_msbc1;
        r_cin   <= c_in;
        for (int k = 0; k < NSEG; k++) begin
          r_sum0[k] <= w_sum0[k];
          r_sum1[k] <= w_sum1[k];
        end
      end else if (w_adv1) begin
        r_v1 <= 1'b0;
      end
    end
  end

  // Stage-2 carry-select chain: one mux level per segment
  logic [NSEG:0]    w_carry;
  logic [WIDTH-1:0] w_sum;
  logic             w_msbc;

  always_comb begin
    w_carry    = '0;
    w_sum      = '0;
    w_carry[0] = r_cin;
    for (int k = 0; k < NSEG; k++) begin
      w_carry[k+1]       = w_carry[k] ? r_cout1[k] : r_cout0[k];
      w_sum[k*BLK +: BLK] = w_carry[k] ? r_sum1[k] : r_sum0[k];
    end
    w_msbc = w_carry[NSEG-1] ? r_msbc1 : r_msbc0;
  end

  // Stage-2 registers
  logic [WIDTH-1:0] r_s;
  logic             r_c_out;
  logic             r_ovf;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v2    <= 1'b0;
      r_s     <= '0;
      r_c_out <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      if (w_adv1) begin
        r_v2    <= 1'b1;
        r_s     <= w_sum;
        r_c_out <= w_carry[NSEG];
        r_ovf   <= w_msbc ^ w_carry[NSEG];
      end else if (r_v2 && out_ready) begin
        r_v2 <= 1'b0;
      end
    end
  end

  assign out_valid = r_v2;
  assign s         = r_s;
  assign c_out     = r_c_out;
  assign ovf       = r_ovf;

endmodule

// File: tb/tb_csa_pipe_adder.sv
// ---------------------------------------------------------------------------
// tb_csa_pipe_adder
//   Directed checks on a WIDTH=32/BLK=8 instance plus a random stream that is
//   also fed (low byte) into a WIDTH=8/BLK=8 instance sharing the handshake.
//   A negedge monitor keeps an in-order scoreboard of reference results.
// ---------------------------------------------------------------------------
module tb_csa_pipe_adder;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        out_ready;
  logic [31:0] a;
  logic [31:0] b;
  logic        c_in;

  logic        in_ready;
  logic        out_valid;
  logic [31:0] s;
  logic        c_out;
  logic        ovf;

  logic        in_ready8;
  logic        out_valid8;
  logic [7:0]  s8;
  logic        c_out8;
  logic        ovf8;

  always #5 clk = ~clk;

  csa_pipe_adder #(.WIDTH(32), .BLK(8)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .c_in(c_in), .out_valid(out_valid), .out_ready(out_ready),
    .s(s), .c_out(c_out), .ovf(ovf)
  );

  csa_pipe_adder #(.WIDTH(8), .BLK(8)) u_dut8 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready8),
    .a(a[7:0]), .b(b[7:0]), .c_in(c_in), .out_valid(out_valid8),
    .out_ready(out_ready), .s(s8), .c_out(c_out8), .ovf(ovf8)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference model
  typedef struct {
    logic [31:0] s;
    logic        c;
    logic        o;
    logic [7:0]  s8;
    logic        c8;
    logic        o8;
  } exp_t;

  function automatic exp_t model(input logic [31:0] aa, input logic [31:0] bb, input logic cc);
    exp_t m;
    logic [32:0] t;
    logic [8:0]  t8;
    t    = {1'b0, aa} + {1'b0, bb} + {32'd0, cc};
    t8   = {1'b0, aa[7:0]} + {1'b0, bb[7:0]} + {8'd0, cc};
    m.s  = t[31:0];
    m.c  = t[32];
    m.o  = (aa[31] == bb[31]) && (t[31] != aa[31]);
    m.s8 = t8[7:0];
    m.c8 = t8[8];
    m.o8 = (aa[7] == bb[7]) && (t8[7] != aa[7]);
    return m;
  endfunction

  // Scoreboard monitor, sampled on the falling edge
  exp_t        q[$];
  exp_t        e;
  int          n_acc   = 0;
  int          n_out   = 0;
  bit          verbose = 1'b1;
  logic        prev_hold = 1'b0;
  logic [33:0] prev_res;

  always @(negedge clk) begin
    if (rst) begin
      q.delete();
      prev_hold = 1'b0;
    end else begin
      check_eq("rdy8", {63'd0, in_ready8}, {63'd0, in_ready});
      check_eq("ovalid8", {63'd0, out_valid8}, {63'd0, out_valid});
      if (prev_hold)
        check_eq("hold_stable", {30'd0, c_out, ovf, s}, {30'd0, prev_res});
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          check_eq("spurious_out", {63'd0, out_valid}, 64'd0);
        end else begin
          e = q.pop_front();
          n_out++;
          check_eq("sb_s", {32'd0, s}, {32'd0, e.s});
          check_eq("sb_cout", {63'd0, c_out}, {63'd0, e.c});
          check_eq("sb_ovf", {63'd0, ovf}, {63'd0, e.o});
          check_eq("sb_s8", {56'd0, s8}, {56'd0, e.s8});
          check_eq("sb_cout8", {63'd0, c_out8}, {63'd0, e.c8});
          check_eq("sb_ovf8", {63'd0, ovf8}, {63'd0, e.o8});
          if (verbose)
            $display("out #%0d: s=%08h c_out=%b ovf=%b | s8=%02h c_out8=%b ovf8=%b",
                     n_out, s, c_out, ovf, s8, c_out8, ovf8);
        end
      end
      if (in_valid && in_ready) begin
        q.push_back(model(a, b, c_in));
        n_acc++;
      end
      prev_hold = out_valid && !out_ready;
      prev_res  = {c_out, ovf, s};
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [31:0] aa, input logic [31:0] bb, input logic cc);
    in_valid = 1'b1;
    a        = aa;
    b        = bb;
    c_in     = cc;
  endtask

  task automatic check_out(input string tag, input logic [31:0] es, input logic ec, input logic eo);
    check_eq({tag, "_valid"}, {63'd0, out_valid}, 64'd1);
    check_eq({tag, "_s"}, {32'd0, s}, {32'd0, es});
    check_eq({tag, "_cout"}, {63'd0, c_out}, {63'd0, ec});
    check_eq({tag, "_ovf"}, {63'd0, ovf}, {63'd0, eo});
  endtask

  logic [31:0] bb_a [4];
  logic [31:0] bb_b [4];
  logic [31:0] bb_s [4];
  logic        bb_c [4];
  int          acc_cnt;
  int          op_idx;
  logic        rdy;
  int          acc_start;
  int          out_start;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    a         = '0;
    b         = '0;
    c_in      = 1'b0;

    // Reset state
    #1;
    check_eq("rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("rst_s", {32'd0, s}, 64'd0);
    check_eq("rst_cout", {63'd0, c_out}, 64'd0);
    check_eq("rst_ovf", {63'd0, ovf}, 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    #1 check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);

    // Full carry ripple, latency
    out_ready = 1'b1;
    drive(32'hFFFF_FFFF, 32'h0, 1'b1);
    #1 check_eq("t1_in_ready", {63'd0, in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    #1 check_eq("t1_lat_valid", {63'd0, out_valid}, 64'd0);
    step();
    check_out("t1", 32'h0, 1'b1, 1'b0);
    step();

    // Signed overflow cases
    drive(32'h7FFF_FFFF, 32'h0000_0001, 1'b0);
    step();
    drive(32'h8000_0000, 32'h8000_0000, 1'b0);
    step();
    check_out("t2a", 32'h8000_0000, 1'b0, 1'b1);
    in_valid = 1'b0;
    step();
    check_out("t2b", 32'h0, 1'b1, 1'b1);
    step();
    check_eq("t2_drained", {63'd0, out_valid}, 64'd0);

    // Back-to-back stream with out_ready held high
    bb_a = '{32'h1, 32'h2, 32'h00FF_00FF, 32'hFFFF_0000};
    bb_b = '{32'h1, 32'h2, 32'h0001_0001, 32'h0001_0000};
    bb_s = '{32'h2, 32'h4, 32'h0100_0100, 32'h0};
    bb_c = '{1'b0, 1'b0, 1'b0, 1'b1};
    for (int i = 0; i < 5; i++) begin
      if (i < 4) begin
        drive(bb_a[i], bb_b[i], 1'b0);
        #1 check_eq("t3_in_ready", {63'd0, in_ready}, 64'd1);
      end else begin
        in_valid = 1'b0;
      end
      step();
      if (i >= 1) check_out("t3", bb_s[i-1], bb_c[i-1], 1'b0);
    end
    step();
    check_eq("t3_drained", {63'd0, out_valid}, 64'd0);

    // Backpressure: pipe absorbs two results
    out_ready = 1'b0;
    acc_cnt   = 0;
    op_idx    = 0;
    for (int i = 0; i < 6; i++) begin
      drive(32'h10 << (4 * op_idx), 32'h20 << (4 * op_idx), 1'b0);
      #1 rdy = in_ready;
      if (rdy) acc_cnt++;
      step();
      if (rdy) op_idx++;
      if (i >= 1) check_out("t4_hold", 32'h30, 1'b0, 1'b0);
    end
    check_eq("t4_accepted", acc_cnt, 64'd2);
    check_eq("t4_in_ready_low", {63'd0, in_ready}, 64'd0);
    out_ready = 1'b1;
    #1 check_eq("t4_passthru", {63'd0, in_ready}, 64'd1);
    step();
    check_out("t4_r1", 32'h300, 1'b0, 1'b0);
    in_valid = 1'b0;
    step();
    check_out("t4_r2", 32'h3000, 1'b0, 1'b0);
    step();
    check_eq("t4_drained", {63'd0, out_valid}, 64'd0);

    // Reset mid-stream
    drive(32'h1111_1111, 32'h2222_2222, 1'b0);
    step();
    drive(32'h3333_3333, 32'h0000_0001, 1'b0);
    step();
    check_eq("t5_pre_valid", {63'd0, out_valid}, 64'd1);
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    check_eq("t5_rst_valid", {63'd0, out_valid}, 64'd0);
    check_eq("t5_rst_s", {32'd0, s}, 64'd0);
    step();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t5_no_stale", {63'd0, out_valid}, 64'd0);
    end

    // Random stream on both widths
    verbose   = 1'b0;
    acc_start = n_acc;
    out_start = n_out;
    for (int cyc = 0; cyc < 40000 && (n_acc - acc_start) < 10000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 7))
        0: a = 32'hFFFF_FFFF;
        1: a = 32'h7FFF_FFFF;
        2: a = 32'h8000_0000;
        default: a = $urandom;
      endcase
      case ($urandom_range(0, 7))
        0: b = 32'hFFFF_FFFF;
        1: b = 32'h0000_0001;
        2: b = 32'h8000_0080;
        default: b = $urandom;
      endcase
      c_in = 1'($urandom_range(0, 1));
      step();
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check_eq("rand_accepted", n_acc - acc_start, 64'd10000);
    for (int i = 0; i < 10 && q.size() != 0; i++) step();
    check_eq("rand_drain_empty", q.size(), 64'd0);
    check_eq("rand_out_count", n_out - out_start, n_acc - acc_start);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
